// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
//   Request/response bundle between the issue stage and the iterative
//   RV32M multiply/divide unit.
//   master (issue side)  : drives start, funct3, op_a, op_b, rd_in, flush;
//                          observes busy, done, result, rd_out.
//   slave  (muldiv_unit) : the mirror image.
interface muldiv_unit_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [2:0]        funct3;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [ADDR_W-1:0] rd_in;
  logic              flush;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic [ADDR_W-1:0] rd_out;

  modport master (
    output start, funct3, op_a, op_b, rd_in, flush,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in, flush,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M execution unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//   Operands are reduced to magnitudes on acceptance, processed one bit per
//   cycle (shift-add multiply, restoring divide), then sign-corrected.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-low reset
//     bus  - muldiv_unit_if.slave: start/funct3/op_a/op_b/rd_in/flush in,
//            busy/done/result/rd_out out
module muldiv_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input logic         clk,
  input logic         rst,
  muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]  lo_q, lo_d;         // multiplier/product-low or dividend/quotient
  logic [WIDTH-1:0]  work_q, work_d;     // product-high or partial remainder
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  result_q, result_d;

  // Operand decode for the incoming request
  logic             in_is_div, in_signed_op, in_signed_a, in_signed_b;
  logic             in_neg_a, in_neg_b, in_div_zero, in_overflow;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;

  // Per-iteration and fix-up datapath
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, fix_sel;

  // Classify the request and form operand magnitudes; signedness of each
  // operand position depends on the opcode (MULHSU treats op_b as unsigned).
  always_comb begin
    in_is_div    = bus.funct3[2];
    in_signed_op = (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    in_signed_a  = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) || in_signed_op;
    in_signed_b  = (bus.funct3 == 3'b001) || in_signed_op;
    in_neg_a     = in_signed_a && bus.op_a[WIDTH-1];
    in_neg_b     = in_signed_b && bus.op_b[WIDTH-1];
    in_mag_a     = in_neg_a ? -bus.op_a : bus.op_a;
    in_mag_b     = in_neg_b ? -bus.op_b : bus.op_b;
    in_div_zero  = in_is_div && (bus.op_b == '0);
    in_overflow  = in_signed_op && (bus.op_a == MIN_VAL) && (bus.op_b == '1);
  end

  // One iteration of each algorithm plus the final sign correction.
  // Multiply shifts {work, lo} right, adding the multiplicand into the high
  // half when the current multiplier bit is set. Divide shifts the next
  // dividend bit into the remainder and keeps the difference if it is >= 0.
  always_comb begin
    mul_sum   = {1'b0, work_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    rem_shift = {work_q, lo_q[WIDTH-1]};
    div_diff  = rem_shift - {1'b0, mcand_q};
    prod_raw  = {work_q, lo_q};
    prod_fix  = (sign_a_q ^ sign_b_q) ? -prod_raw : prod_raw;
    quot_fix  = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
    rem_fix   = sign_a_q ? -work_q : work_q;
    unique case (funct3_q)
      3'b000:                 fix_sel = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_sel = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_sel = quot_fix;
      default:                fix_sel = rem_fix;
    endcase
  end

  // Next-state logic. flush wins over everything and leaves all state but
  // the FSM untouched, so result keeps its previous value.
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    mcand_d  = mcand_q;
    lo_d     = lo_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            funct3_d = bus.funct3;
            rd_d     = bus.rd_in;
            sign_a_d = in_neg_a;
            sign_b_d = in_neg_b;
            cnt_d    = '0;
            work_d   = '0;
            mcand_d  = in_is_div ? in_mag_b : in_mag_a;
            lo_d     = in_is_div ? in_mag_a : in_mag_b;
            // Divide-by-zero and signed overflow skip iteration entirely
            if (in_div_zero) begin
              result_d = bus.funct3[1] ? bus.op_a : '1;
              state_d  = DONE;
            end else if (in_overflow) begin
              result_d = bus.funct3[1] ? '0 : bus.op_a;
              state_d  = DONE;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          cnt_d = cnt_q + 1'b1;
          if (funct3_q[2]) begin
            if (!div_diff[WIDTH]) begin
              work_d = div_diff[WIDTH-1:0];
              lo_d   = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
              work_d = rem_shift[WIDTH-1:0];
              lo_d   = {lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            work_d = mul_sum[WIDTH:1];
            lo_d   = {mul_sum[0], lo_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
        end
        FIX: begin
          result_d = fix_sel;
          state_d  = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register; reset clears every flop so an interrupted op leaves
  // nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      rd_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mcand_q  <= '0;
      lo_q     <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      mcand_q  <= mcand_d;
      lo_q     <= lo_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Outputs are pure decodes of flops
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Directed-vector bench for muldiv_unit: every opcode, the divide special
//   cases, latency, and the start-while-busy / flush / reset aborts.
module tb_muldiv_unit;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  logic clk;
  logic rst;
  int   testsRun  = 0;
  int   failCount = 0;

  muldiv_unit_if #(.WIDTH(32), .ADDR_W(5)) bus ();

  muldiv_unit #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Present a request for one cycle; returns at the falling edge after E0
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    waitCycles(1);
    bus.start  = 1'b0;
  endtask

  // Count edges after E0 until done, bounded
  task automatic waitDone(input int startLat, output int lat);
    lat = startLat;
    while (!bus.done && lat < 45) begin
      waitCycles(1);
      lat++;
    end
  endtask

  // Full transaction: start, latency, result, rd, and return to idle
  task automatic runOp(input string tag, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] expResult,
                       input int expLat);
    int lat;
    applyStimulus(f3, a, b, rd);
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd1);
    waitDone(0, lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, " result"}, bus.result, expResult);
    checkOutput({tag, " rd_out"}, 32'(bus.rd_out), 32'(rd));
    waitCycles(1);
    checkOutput({tag, " done drop"}, 32'(bus.done), 32'd0);
    checkOutput({tag, " idle"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, " result hold"}, bus.result, expResult);
  endtask

  initial begin
    int lat;
    int doneSeen;
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = '0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.rd_in  = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset result", bus.result, 32'd0);
    checkOutput("reset rd_out", 32'(bus.rd_out), 32'd0);
    rst = 1'b1;
    waitCycles(1);

    // Normal operations
    runOp("MUL 7*6",      F_MUL,    32'd7,        32'd6,        5'd1,  32'h0000002A, 33);
    runOp("MULH -2*3",    F_MULH,   32'hFFFFFFFE, 32'd3,        5'd2,  32'hFFFFFFFF, 33);
    runOp("MULHU max^2",  F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 33);
    runOp("MULHSU -1*2",  F_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, 33);
    runOp("DIV -7/2",     F_DIV,    32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 33);
    runOp("REM -7/2",     F_REM,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 33);
    runOp("DIVU 100/7",   F_DIVU,   32'd100,      32'd7,        5'd0,  32'd14,       33);
    runOp("REMU 100/7",   F_REMU,   32'd100,      32'd7,        5'd31, 32'd2,        33);
    runOp("MUL -3*5 low", F_MUL,    32'hFFFFFFFD, 32'd5,        5'd9,  32'hFFFFFFF1, 33);

    // Special cases complete in the cycle after E0
    runOp("DIVU 5/0",     F_DIVU,   32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 0);
    runOp("REMU 5/0",     F_REMU,   32'd5,        32'd0,        5'd11, 32'd5,        0);
    runOp("DIV ovf",      F_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 0);
    runOp("REM ovf",      F_REM,    32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        0);

    // Start while busy must not disturb the op in flight
    applyStimulus(F_MUL, 32'd7, 32'd6, 5'd3);
    waitCycles(9);
    bus.start  = 1'b1;
    bus.funct3 = F_DIV;
    bus.op_a   = 32'd3;
    bus.op_b   = 32'd9;
    bus.rd_in  = 5'd9;
    waitCycles(1);
    bus.start  = 1'b0;
    waitDone(10, lat);
    checkOutput("restart latency", 32'(lat), 32'd33);
    checkOutput("restart result", bus.result, 32'h0000002A);
    checkOutput("restart rd_out", 32'(bus.rd_out), 32'd3);
    waitCycles(1);
    checkOutput("restart idle", 32'(bus.busy), 32'd0);

    // Flush mid-operation: no done, result keeps the previous value
    applyStimulus(F_DIVU, 32'd100, 32'd7, 5'd4);
    waitCycles(9);
    bus.flush = 1'b1;
    waitCycles(1);
    bus.flush = 1'b0;
    checkOutput("flush busy", 32'(bus.busy), 32'd0);
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) doneSeen++;
      waitCycles(1);
    end
    checkOutput("flush no done", 32'(doneSeen), 32'd0);
    checkOutput("flush result hold", bus.result, 32'h0000002A);
    runOp("REMU after flush", F_REMU, 32'd100, 32'd7, 5'd8, 32'd2, 33);

    // Asynchronous reset mid-operation
    applyStimulus(F_MUL, 32'd5, 32'd5, 5'd7);
    waitCycles(19);
    #2 rst = 1'b0;
    #1;
    checkOutput("async rst busy", 32'(bus.busy), 32'd0);
    checkOutput("async rst done", 32'(bus.done), 32'd0);
    checkOutput("async rst result", bus.result, 32'd0);
    checkOutput("async rst rd_out", 32'(bus.rd_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    waitCycles(1);
    runOp("MUL after reset", F_MUL, 32'd123, 32'd3, 5'd8, 32'h00000171, 33);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, directly downstream of the register file read ports.
- Takes the two source operands (REG_DATA1/REG_DATA2 values) plus the destination register index.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles.
- Returns a result and rd index on a one-cycle done strobe for the write-back path (WR_DATA/ADR_WR_REG).

Parameters:
- WIDTH, 32, operand/result width in bits.
- ADDR_W, 5, destination register index width.

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  WIDTH  rs1 value (multiplicand/dividend).
- op_b  input  WIDTH  rs2 value (multiplier/divisor).
- rd_in  input  ADDR_W  destination register index.
- flush  input  1  synchronous abort (pipeline kill).
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle strobe: result/rd_out valid.
- result  output  WIDTH  computed value.
- rd_out  output  ADDR_W  latched rd_in of the current op.

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0, done=0, result=0, rd_out=0; all internal regs cleared. Reset asserted mid-operation aborts it, and no done is produced.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE, start=1 at edge E0:
  - Latch funct3, rd_in, and operand signs.
  - Latch |op_a| and |op_b| for signed operand positions: MULH both; MULHSU op_a only; DIV/REM both. All others unsigned.
  - Clear the iteration counter.
  - Go to CALC, except for special cases (below), which go straight to DONE.
- Special cases, decided at E0, go to DONE with the result loaded; done is high in the cycle after E0:
  - Divide by zero (op_b=0), DIV/DIVU: result = all ones.
  - Divide by zero (op_b=0), REM/REMU: result = op_a.
  - Signed overflow (DIV/REM, op_a=1<<(WIDTH-1), op_b=all ones), DIV: result = op_a.
  - Signed overflow, REM: result = 0.
- CALC: one iteration per edge, WIDTH iterations (edges E1..EWIDTH). After the last iteration, go to FIX.
  - Multiply: radix-2 shift-add into a 2*WIDTH-bit product.
  - Divide: restoring, one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
- FIX (edge EWIDTH+1): apply the sign correction, select the result, go to DONE.
  - Multiply: negate the 2*WIDTH-bit product if the signs differ (signed positions only).
  - Quotient: negate if the signs differ.
  - Remainder: takes the dividend's sign.
  - Result select: MUL takes the low WIDTH bits; MULH/MULHSU/MULHU take the high WIDTH bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge. start during DONE is ignored.
- Normal-op latency: done high after edge E(WIDTH+1), i.e. 33 edges after the start edge for WIDTH=32. Back-to-back throughput is 1 op per WIDTH+3 cycles.
- start while busy=1: ignored; the operation in flight is unaffected.
- Output stability: result and rd_out hold their value after done until the next accepted start. done is never asserted outside DONE.
- flush=1 on any edge: go to IDLE; done stays 0; result holds its old value. flush has priority over start in the same cycle.
- rd_in=0 is processed normally; x0 protection is the register file's job.
- All arithmetic is two's complement, modulo 2^WIDTH; no exceptions are raised.

Test Plan:
- MUL, op_a=7, op_b=6 -> busy rises after E0; done=1 exactly 33 edges after start; result=0x0000002A; rd_out=rd_in.
- MULH, op_a=0xFFFFFFFE (-2), op_b=3 -> result=0xFFFFFFFF.
- MULHU, 0xFFFFFFFF*0xFFFFFFFF -> result=0xFFFFFFFE.
- MULHSU, op_a=-1, op_b=2 -> result=0xFFFFFFFF.
- DIV/REM, op_a=0xFFFFFFF9 (-7), op_b=2 -> DIV result=0xFFFFFFFD; REM result=0xFFFFFFFF.
- DIVU, op_a=100, op_b=7 -> result=14; REMU -> result=2.
- Special cases, each with done one cycle after start and busy for 1 cycle:
  - DIVU 5/0 -> result=0xFFFFFFFF.
  - REMU 5/0 -> result=5.
  - DIV 0x80000000/0xFFFFFFFF -> result=0x80000000.
  - REM, same operands -> result=0.
- Abort behaviour:
  - Second start pulse at cycle 10 of a MUL -> ignored; the first result is unchanged.
  - flush at cycle 10 -> busy=0 next cycle; no done.
  - rst low at cycle 20 -> all outputs 0 immediately (async).
  - A new start after either abort completes correctly.
